// File: rtl/ppg_beat_extractor.sv
// ppg_beat_extractor: tracks IR peaks and valleys with hysteresis and reports,
// for every valley-to-valley window, the beat period plus peak-to-peak (AC)
// and mid-level (DC) figures for the IR and red channels.
//
// Sample interface: sample_en is a one-cycle valid with no ready. The block is
// always ready, so every cycle with sample_en=1 and enable=1 consumes exactly
// one RED/IR pair. Back-to-back strobes give one sample per clock.
module ppg_beat_extractor #(
    parameter logic [7:0] HYST       = 8'd8,
    parameter int         MIN_PERIOD = 30,
    parameter int         MAX_PERIOD = 300,
    parameter int         PER_W      = 12
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sample_en,
    input  logic [7:0]       RED_ADC_Value,
    input  logic [7:0]       IR_ADC_Value,
    output logic             beat_valid,
    output logic             beat_err,
    output logic [PER_W-1:0] beat_period,
    output logic [7:0]       IR_AC,
    output logic [7:0]       RED_AC,
    output logic [7:0]       IR_DC,
    output logic [7:0]       RED_DC,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        RISE    = 2'd2,
        FALL    = 2'd3
    } state_t;

    localparam logic [8:0]       HYST9   = {1'b0, HYST};
    localparam logic [PER_W-1:0] MIN_CNT = PER_W'(MIN_PERIOD);
    localparam logic [PER_W-1:0] MAX_CNT = PER_W'(MAX_PERIOD);

    state_t           state_q, state_d;
    logic [7:0]       vl_q, vl_d;
    logic [7:0]       pk_q, pk_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ir_hi_q, ir_hi_d, ir_lo_q, ir_lo_d;
    logic [7:0]       red_hi_q, red_hi_d, red_lo_q, red_lo_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [7:0]       ir_ac_q, ir_ac_d, ir_dc_q, ir_dc_d;
    logic [7:0]       red_ac_q, red_ac_d, red_dc_q, red_dc_d;
    logic             valid_q, valid_d, err_q, err_d;

    logic [7:0]       vl_min, pk_max;
    logic [7:0]       ir_hi_s, ir_lo_s, red_hi_s, red_lo_s;
    logic [8:0]       ir_sum, red_sum;
    logic             valley_hit, peak_hit, timeout;
    logic [PER_W-1:0] cnt_inc;

    // Trackers folded with the current sample; all compares and sums in 9 bits
    always_comb begin
        vl_min     = (IR_ADC_Value < vl_q) ? IR_ADC_Value : vl_q;
        pk_max     = (IR_ADC_Value > pk_q) ? IR_ADC_Value : pk_q;
        ir_hi_s    = (IR_ADC_Value > ir_hi_q) ? IR_ADC_Value : ir_hi_q;
        ir_lo_s    = (IR_ADC_Value < ir_lo_q) ? IR_ADC_Value : ir_lo_q;
        red_hi_s   = (RED_ADC_Value > red_hi_q) ? RED_ADC_Value : red_hi_q;
        red_lo_s   = (RED_ADC_Value < red_lo_q) ? RED_ADC_Value : red_lo_q;
        valley_hit = ({1'b0, IR_ADC_Value} >= ({1'b0, vl_min} + HYST9));
        peak_hit   = (({1'b0, IR_ADC_Value} + HYST9) <= {1'b0, pk_max});
        cnt_inc    = cnt_q + PER_W'(1);
        timeout    = (cnt_q == MAX_CNT);
        ir_sum     = {1'b0, ir_hi_s} + {1'b0, ir_lo_s};
        red_sum    = {1'b0, red_hi_s} + {1'b0, red_lo_s};
    end

    // Next-state and register updates; enable low wins over any sample
    always_comb begin
        state_d  = state_q;
        vl_d     = vl_q;
        pk_d     = pk_q;
        cnt_d    = cnt_q;
        ir_hi_d  = ir_hi_q;
        ir_lo_d  = ir_lo_q;
        red_hi_d = red_hi_q;
        red_lo_d = red_lo_q;
        period_d = period_q;
        ir_ac_d  = ir_ac_q;
        ir_dc_d  = ir_dc_q;
        red_ac_d = red_ac_q;
        red_dc_d = red_dc_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    vl_d    = 8'hFF;
                end
                ACQUIRE: begin
                    if (sample_en) begin
                        vl_d = vl_min;
                        // First valley only arms the window; no beat yet
                        if (valley_hit) begin
                            state_d  = RISE;
                            pk_d     = IR_ADC_Value;
                            cnt_d    = '0;
                            ir_hi_d  = 8'h00;
                            ir_lo_d  = 8'hFF;
                            red_hi_d = 8'h00;
                            red_lo_d = 8'hFF;
                        end
                    end
                end
                RISE: begin
                    if (sample_en) begin
                        cnt_d    = cnt_inc;
                        pk_d     = pk_max;
                        ir_hi_d  = ir_hi_s;
                        ir_lo_d  = ir_lo_s;
                        red_hi_d = red_hi_s;
                        red_lo_d = red_lo_s;
                        if (timeout) begin
                            err_d   = 1'b1;
                            state_d = ACQUIRE;
                            vl_d    = IR_ADC_Value;
                            cnt_d   = '0;
                        end else if (peak_hit) begin
                            state_d = FALL;
                            vl_d    = IR_ADC_Value;
                        end
                    end
                end
                FALL: begin
                    if (sample_en) begin
                        cnt_d    = cnt_inc;
                        vl_d     = vl_min;
                        ir_hi_d  = ir_hi_s;
                        ir_lo_d  = ir_lo_s;
                        red_hi_d = red_hi_s;
                        red_lo_d = red_lo_s;
                        if (valley_hit) begin
                            // Window closes on the confirming sample, which it includes
                            if (cnt_inc >= MIN_CNT) begin
                                valid_d  = 1'b1;
                                period_d = cnt_inc;
                                ir_ac_d  = ir_hi_s - ir_lo_s;
                                ir_dc_d  = ir_sum[8:1];
                                red_ac_d = red_hi_s - red_lo_s;
                                red_dc_d = red_sum[8:1];
                            end else begin
                                err_d = 1'b1;
                            end
                            state_d  = RISE;
                            pk_d     = IR_ADC_Value;
                            cnt_d    = '0;
                            ir_hi_d  = 8'h00;
                            ir_lo_d  = 8'hFF;
                            red_hi_d = 8'h00;
                            red_lo_d = 8'hFF;
                        end else if (timeout) begin
                            err_d   = 1'b1;
                            state_d = ACQUIRE;
                            vl_d    = IR_ADC_Value;
                            cnt_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vl_q     <= 8'hFF;
            pk_q     <= 8'h00;
            cnt_q    <= '0;
            ir_hi_q  <= 8'h00;
            ir_lo_q  <= 8'hFF;
            red_hi_q <= 8'h00;
            red_lo_q <= 8'hFF;
            period_q <= '0;
            ir_ac_q  <= 8'h00;
            ir_dc_q  <= 8'h00;
            red_ac_q <= 8'h00;
            red_dc_q <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vl_q     <= vl_d;
            pk_q     <= pk_d;
            cnt_q    <= cnt_d;
            ir_hi_q  <= ir_hi_d;
            ir_lo_q  <= ir_lo_d;
            red_hi_q <= red_hi_d;
            red_lo_q <= red_lo_d;
            period_q <= period_d;
            ir_ac_q  <= ir_ac_d;
            ir_dc_q  <= ir_dc_d;
            red_ac_q <= red_ac_d;
            red_dc_q <= red_dc_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign beat_valid  = valid_q;
    assign beat_err    = err_q;
    assign beat_period = period_q;
    assign IR_AC       = ir_ac_q;
    assign IR_DC       = ir_dc_q;
    assign RED_AC      = red_ac_q;
    assign RED_DC      = red_dc_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ppg_beat_extractor.sv
// Bench for ppg_beat_extractor: scripted IR/red waveforms, expected beat
// events queued at the confirming sample and matched against pulses.
module tb_ppg_beat_extractor;

    localparam int W = 61;   // {due cycle[15:0], err, period[11:0], ir_ac, ir_dc, red_ac, red_dc}

    localparam logic [44:0] TRI_PL      = {1'b0, 12'd80, 8'd80, 8'd140, 8'd40, 8'd130};
    localparam logic [44:0] TRI_ERR_PL  = {1'b1, 12'd80, 8'd80, 8'd140, 8'd40, 8'd130};
    localparam logic [44:0] ZERO_ERR_PL = {1'b1, 44'd0};
    localparam logic [44:0] SQ_PL       = {1'b0, 12'd60, 8'd255, 8'd127, 8'd0, 8'd50};
    localparam logic [44:0] NO_PL       = 45'd0;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sample_en;
    logic [7:0]  RED_ADC_Value;
    logic [7:0]  IR_ADC_Value;
    logic        beat_valid;
    logic        beat_err;
    logic [11:0] beat_period;
    logic [7:0]  IR_AC, RED_AC, IR_DC, RED_DC;
    logic [1:0]  state_dbg;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] cyc      = 16'd0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_head;

    ppg_beat_extractor dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .enable        (enable),
        .sample_en     (sample_en),
        .RED_ADC_Value (RED_ADC_Value),
        .IR_ADC_Value  (IR_ADC_Value),
        .beat_valid    (beat_valid),
        .beat_err      (beat_err),
        .beat_period   (beat_period),
        .IR_AC         (IR_AC),
        .RED_AC        (RED_AC),
        .IR_DC         (IR_DC),
        .RED_DC        (RED_DC),
        .state_dbg     (state_dbg)
    );

    // Clock and cycle counter
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 16'd1;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Scoreboard: match every pulse to the head of the expected queue
    always @(negedge CLK) begin
        if (exp_q.size() != 0 && exp_q[0][W-1:45] < cyc) begin
            n_assert = n_assert + 1;
            n_fail   = n_fail + 1;
            $display("FAIL missed_pulse: no pulse by cycle %0d, required at cycle %0d", cyc, exp_q[0][W-1:45]);
            mon_head = exp_q.pop_front();
        end
        if (beat_valid || beat_err) begin
            n_assert = n_assert + 1;
            if (beat_valid && beat_err) begin
                n_fail = n_fail + 1;
                $display("FAIL pulse_exclusive: valid=1 err=1 at cycle %0d, required at most one", cyc);
            end
            n_assert = n_assert + 1;
            if (exp_q.size() == 0 || exp_q[0][W-1:45] != cyc) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b at cycle %0d, required no pulse", beat_valid, beat_err, cyc);
            end else begin
                mon_head = exp_q.pop_front();
                n_assert = n_assert + 1;
                if ({beat_err, beat_period, IR_AC, IR_DC, RED_AC, RED_DC} !== mon_head[44:0]) begin
                    n_fail = n_fail + 1;
                    $display("FAIL beat_fields: got err=%0b per=%0d irac=%0d irdc=%0d redac=%0d reddc=%0d, required err=%0b per=%0d irac=%0d irdc=%0d redac=%0d reddc=%0d",
                             beat_err, beat_period, IR_AC, IR_DC, RED_AC, RED_DC,
                             mon_head[44], mon_head[43:32], mon_head[31:24], mon_head[23:16], mon_head[15:8], mon_head[7:0]);
                end
            end
        end
    end

    // Driver: one sample per negedge, optionally queueing the expected event
    task automatic send(input logic [7:0] red, input logic [7:0] ir, input bit push, input logic [44:0] pl);
        @(negedge CLK);
        sample_en     = 1'b1;
        RED_ADC_Value = red;
        IR_ADC_Value  = ir;
        if (push) exp_q.push_back({cyc + 16'd1, pl});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            sample_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        sample_en = 1'b0;
        enable    = 1'b0;
        rst_n     = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    // Triangle IR 100..180..100 (step 2), red 110..150, period 80; valley confirmed at phase 4
    task automatic send_triangle(input int n0, input int n1);
        for (int n = n0; n < n1; n++) begin
            int p;
            int t;
            p = n % 80;
            t = (p < 40) ? p : 80 - p;
            send(8'(110 + t), 8'(100 + 2 * t), (n >= 80 && p == 4), TRI_PL);
        end
    endtask

    task automatic check_drained(input string tag);
        n_assert = n_assert + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL %s_drained: %0d expected pulses outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; sample_en = 1'b0;
        RED_ADC_Value = 8'd0; IR_ADC_Value = 8'd0;
        idle(3);
        n_assert = n_assert + 1;
        if (beat_valid !== 1'b0 || beat_err !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_pulses: valid=%0b err=%0b, required 0 0", beat_valid, beat_err);
        end
        n_assert = n_assert + 1;
        if (beat_period !== 12'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_period: got %0d, required 0", beat_period);
        end
        n_assert = n_assert + 1;
        if ({IR_AC, IR_DC, RED_AC, RED_DC} !== 32'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_acdc: got %h, required 0", {IR_AC, IR_DC, RED_AC, RED_DC});
        end
        n_assert = n_assert + 1;
        if (state_dbg !== 2'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_state: got %0d, required 0", state_dbg);
        end
        @(negedge CLK);
        rst_n = 1'b1;
        idle(3);
        n_assert = n_assert + 1;
        if (state_dbg !== 2'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL idle_hold: state %0d with enable low, required 0", state_dbg);
        end
    endtask

    task automatic test_short_period();
        enable = 1'b1;
        idle(2);
        n_assert = n_assert + 1;
        if (state_dbg !== 2'd1) begin
            n_fail = n_fail + 1;
            $display("FAIL acquire_entry: state %0d, required 1", state_dbg);
        end
        // Period 20, amplitude 60: valley confirmed at phase 2, each window 20 < 30
        for (int n = 0; n < 100; n++) begin
            int p;
            int t;
            p = n % 20;
            t = (p < 10) ? p : 20 - p;
            send(8'd100, 8'(100 + 6 * t), (n >= 20 && p == 2), ZERO_ERR_PL);
        end
        idle(3);
        check_drained("short");
        n_assert = n_assert + 1;
        if ({beat_period, IR_AC, IR_DC, RED_AC, RED_DC} !== 44'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL short_outputs: got per=%0d irac=%0d irdc=%0d, required all 0", beat_period, IR_AC, IR_DC);
        end
    endtask

    task automatic test_triangle();
        do_reset();
        enable = 1'b1;
        idle(2);
        send_triangle(0, 485);
        idle(3);
        check_drained("triangle");
        n_assert = n_assert + 1;
        if (state_dbg !== 2'd2) begin
            n_fail = n_fail + 1;
            $display("FAIL triangle_state: got %0d, required 2", state_dbg);
        end
    endtask

    task automatic test_dither();
        enable = 1'b0;
        idle(2);
        n_assert = n_assert + 1;
        if (state_dbg !== 2'd0 || {beat_period, IR_AC, IR_DC, RED_AC, RED_DC} !== TRI_PL[43:0]) begin
            n_fail = n_fail + 1;
            $display("FAIL idle_hold_outputs: state=%0d per=%0d irdc=%0d, required 0 80 140", state_dbg, beat_period, IR_DC);
        end
        enable = 1'b1;
        idle(2);
        for (int r = 0; r < 3; r++) begin
            send(8'd120, 8'd100, 1'b0, NO_PL);
            send(8'd120, 8'd128, 1'b0, NO_PL);
            for (int i = 1; i <= 301; i++)
                send(8'd120, 8'($urandom_range(131, 125)), (i == 301), TRI_ERR_PL);
            idle(1);
            n_assert = n_assert + 1;
            if (state_dbg !== 2'd1) begin
                n_fail = n_fail + 1;
                $display("FAIL timeout_state: round %0d state %0d, required 1", r, state_dbg);
            end
        end
        for (int i = 0; i < 200; i++)
            send(8'd120, 8'($urandom_range(131, 125)), 1'b0, NO_PL);
        idle(3);
        check_drained("dither");
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        idle(2);
        send_triangle(0, 100);
        @(negedge CLK);
        enable        = 1'b0;
        sample_en     = 1'b1;
        IR_ADC_Value  = 8'd250;
        RED_ADC_Value = 8'd250;
        @(negedge CLK);
        sample_en = 1'b0;
        n_assert = n_assert + 1;
        if (state_dbg !== 2'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL drop_state: got %0d, required 0", state_dbg);
        end
        n_assert = n_assert + 1;
        if ({beat_period, IR_AC, IR_DC, RED_AC, RED_DC} !== TRI_PL[43:0]) begin
            n_fail = n_fail + 1;
            $display("FAIL drop_hold: per=%0d irac=%0d irdc=%0d redac=%0d reddc=%0d, required 80 80 140 40 130",
                     beat_period, IR_AC, IR_DC, RED_AC, RED_DC);
        end
        enable = 1'b1;
        idle(2);
        send_triangle(0, 165);
    endtask

    task automatic test_reset_mid_fall();
        send_triangle(165, 220);
        @(negedge CLK);
        sample_en = 1'b0;
        n_assert = n_assert + 1;
        if (state_dbg !== 2'd3) begin
            n_fail = n_fail + 1;
            $display("FAIL prereset_state: got %0d, required 3", state_dbg);
        end
        rst_n = 1'b0;
        #1;
        n_assert = n_assert + 1;
        if ({beat_valid, beat_err, beat_period, IR_AC, IR_DC, RED_AC, RED_DC, state_dbg} !== 48'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL async_clear: per=%0d irac=%0d irdc=%0d state=%0d, required all 0", beat_period, IR_AC, IR_DC, state_dbg);
        end
        @(negedge CLK);
        rst_n = 1'b1;
        idle(2);
        send_triangle(0, 245);
        idle(3);
        check_drained("recovery");
    endtask

    task automatic test_square();
        do_reset();
        enable = 1'b1;
        idle(2);
        for (int n = 0; n < 271; n++)
            send(8'd50, ((n % 60) < 30) ? 8'd0 : 8'd255, (n >= 90 && (n % 60) == 30), SQ_PL);
        idle(3);
        check_drained("square");
        n_assert = n_assert + 1;
        if (IR_AC !== 8'd255 || IR_DC !== 8'd127) begin
            n_fail = n_fail + 1;
            $display("FAIL square_edges: irac=%0d irdc=%0d, required 255 127", IR_AC, IR_DC);
        end
    endtask

    initial begin
        test_reset();
        test_short_period();
        test_triangle();
        test_dither();
        test_enable_drop();
        test_reset_mid_fall();
        test_square();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ppg_beat_extractor.md
# ppg_beat_extractor

Downstream consumer of the LED/PGA controller in the pulse-oximeter chain. It takes the per-channel sample values `RED_ADC_Value` and `IR_ADC_Value` that the controller produces once settings are locked. It detects heartbeats on the IR channel using hysteretic peak/valley tracking. For each valid beat it emits the beat period, plus AC (peak-to-peak) and DC (mid-level) figures for both channels, which feed the SpO2 ratio and heart-rate stages.

## Interface
- `HYST`, default 8: peak/valley confirmation hysteresis in ADC LSB, 8-bit.
- `MIN_PERIOD`, default 30: shortest accepted beat, in samples.
- `MAX_PERIOD`, default 300: longest accepted beat, in samples; timeout bound.
- `PER_W`, default 12: width of the period counter and `beat_period`; must satisfy 2^PER_W > MAX_PERIOD.

Ports:
- `CLK`  in  1  single clock, rising edge. One clock; all state is sampled on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  high while controller settings are complete; low forces IDLE.
- `sample_en`  in  1  one-cycle strobe; RED/IR values are new and stable this cycle.
- `RED_ADC_Value`  in  8  red channel sample.
- `IR_ADC_Value`  in  8  IR channel sample.
- `beat_valid`  out  1  one-cycle pulse; beat outputs updated.
- `beat_err`  out  1  one-cycle pulse; beat rejected (too short or timeout).
- `beat_period`  out  PER_W  samples in the last valid beat window.
- `IR_AC`, `RED_AC`  out  8  hi − lo over the beat window.
- `IR_DC`, `RED_DC`  out  8  (hi + lo) >> 1, computed with a 9-bit sum.
- `state_dbg`  out  2  current FSM state: IDLE=0, ACQUIRE=1, RISE=2, FALL=3.

## Operation
- A sample is accepted only when `sample_en`=1 and `enable`=1. Nothing changes when `sample_en`=0.
- **IDLE:** holds all beat outputs.
  - `enable`=1 → ACQUIRE; valley tracker `vl` ← 255.
- **ACQUIRE:** `vl` ← min(`vl`, ir).
  - If ir ≥ `vl`+`HYST` (9-bit compare): first valley confirmed → RISE.
  - On that transition: `pk` ← ir, `cnt` ← 0, window trackers reset (hi=0, lo=255 for both channels). No beat is emitted.
- **RISE:** `pk` ← max(`pk`, ir).
  - If ir + `HYST` ≤ `pk`: peak confirmed → FALL, `vl` ← ir.
- **FALL:** `vl` ← min(`vl`, ir).
  - If ir ≥ `vl`+`HYST`: valley confirmed → end of window → RISE, `pk` ← ir.
- **Window counting (RISE/FALL):** on every accepted sample, `cnt` increments, and IR/red hi/lo update with the sample, including the confirming sample.
- **At valley confirmation** (`cnt` already includes the confirming sample):
  - If `cnt` ≥ `MIN_PERIOD`: latch `beat_period`=`cnt` and AC/DC for both channels; pulse `beat_valid`.
  - Else: pulse `beat_err`; outputs hold.
  - Either way: `cnt` ← 0 and window trackers reset.
- **Timeout:** an accepted sample in RISE/FALL with `cnt` = `MAX_PERIOD` that does not confirm a valley causes:
  - a `beat_err` pulse;
  - → ACQUIRE, with `vl` ← ir and `cnt` ← 0.
- `enable`=0 → IDLE in the next cycle from any state. `enable` low has priority over a coincident `sample_en`; that sample is dropped.
- **Arithmetic:** all compares and the DC sum are done in 9 bits; no wrap. `HYST`=0 is legal: any change confirms.

## Timing
- **Reset values:**
  - `beat_valid`=0, `beat_err`=0.
  - `beat_period`=0, all AC/DC outputs=0.
  - `state_dbg`=IDLE, `cnt`=0, `pk`=0, `vl`=255, window trackers hi=0 / lo=255.
- **Latency:** `beat_valid`/`beat_err` assert in the cycle after the confirming `sample_en` and last exactly 1 cycle. Beat outputs change in that same cycle and hold until the next `beat_valid`.
- `beat_valid` and `beat_err` are never high together.
- Consecutive `sample_en` on back-to-back cycles must be supported; the throughput is one sample per clock.
- **`rst_n` low mid-beat:** immediate asynchronous clear to reset values; no pulse.
- After `enable` returns high, the first `beat_valid` requires a full ACQUIRE valley plus one complete window.

## Test plan
- Triangle IR 100→180→100, period 80 samples, with red 110→150 in phase:
  - After the first window, `beat_valid` fires every 80 samples.
  - Each pulse shows `beat_period`=80, `IR_AC`=80, `IR_DC`=140, `RED_AC`=40, `RED_DC`=130.
- IR dither ±3 around 128 (below `HYST`=8):
  - No `beat_valid`.
  - `beat_err` fires once every 301 accepted samples after the first valley; `state_dbg` returns to ACQUIRE each time.
- Triangle of period 20 samples, amplitude 60:
  - `beat_err` on each valley confirmation.
  - `beat_valid` never asserts; outputs stay 0.
- `enable` dropped mid-RISE with coincident `sample_en`:
  - `state_dbg`=IDLE next cycle; prior beat outputs unchanged.
  - On re-enable with the 80-sample triangle, the first `beat_valid` carries `beat_period`=80.
- `rst_n` pulsed low during FALL:
  - All outputs are 0 the same cycle; no pulses.
  - Recovery matches the first scenario.
- Edge values: IR square wave 0↔255, period 60:
  - `IR_AC`=255, `IR_DC`=127; no overflow.
